// File: rtl/cpu_core_if.sv
// Shared word-addressed memory port between the core (master) and memory (slave).
// Each request is held stable until the slave completes it with mem_ready.
interface cpu_core_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/cpu_core.sv
// Multi-cycle FETCH/EXEC/MEM/WB core with per-register flags, branches,
// loads/stores, HALT and sticky illegal-opcode trap.
module cpu_core #(
  parameter int unsigned   DW       = 32,
  parameter int unsigned   AW       = 32,
  parameter int unsigned   NREGS    = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clock,
  input  logic          reset,
  cpu_core_if.master    bus,
  output logic          retire,
  output logic          halted,
  output logic          illegal,
  output logic [AW-1:0] pc
);

  localparam int unsigned RW = $clog2(NREGS);

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_XOR  = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd6;
  localparam logic [5:0] OP_LD   = 6'd7;
  localparam logic [5:0] OP_ST   = 6'd8;
  localparam logic [5:0] OP_BZ   = 6'd9;
  localparam logic [5:0] OP_BF   = 6'd10;
  localparam logic [5:0] OP_JMP  = 6'd11;
  localparam logic [5:0] OP_HALT = 6'd12;

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] pcn_q, pcn_d;
  logic [31:0]   ir_q, ir_d;
  logic [DW-1:0] res_q, res_d;
  logic          fres_q, fres_d;
  logic          rwe_q, rwe_d;
  logic          fwe_q, fwe_d;
  logic          is_ld_q, is_ld_d;
  logic [RW-1:0] rd_q, rd_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          retire_q, retire_d;
  logic          halted_q, halted_d;
  logic          illegal_q, illegal_d;

  logic [DW-1:0] regs_q [NREGS];
  logic [NREGS-1:0] flags_q;

  // Instruction decode and operand fetch; sources read pre-writeback values.
  logic [5:0]    op;
  logic [RW-1:0] rd, rs1, rs2;
  logic [DW-1:0] a, b, imm_sx;
  logic [DW:0]   sum_add, sum_addi;
  logic [AW-1:0] ea, pc_inc, pc_br;

  assign op       = ir_q[5:0];
  assign rd       = RW'(ir_q[9:6]);
  assign rs1      = RW'(ir_q[13:10]);
  assign rs2      = RW'(ir_q[17:14]);
  assign imm_sx   = DW'($signed(ir_q[31:18]));
  assign a        = regs_q[rs1];
  assign b        = regs_q[rs2];
  assign sum_add  = {1'b0, a} + {1'b0, b};
  assign sum_addi = {1'b0, a} + {1'b0, imm_sx};
  assign ea       = AW'(a + imm_sx);
  assign pc_inc   = pc_q + AW'(1);
  assign pc_br    = pc_q + AW'(imm_sx);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pcn_d     = pcn_q;
    ir_d      = ir_q;
    res_d     = res_q;
    fres_d    = fres_q;
    rwe_d     = rwe_q;
    fwe_d     = fwe_q;
    is_ld_d   = is_ld_q;
    rd_d      = rd_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    retire_d  = 1'b0;
    halted_d  = halted_q;
    illegal_d = illegal_q;

    case (state_q)
      S_FETCH: begin
        if (!req_q) begin
          // Only reachable straight out of reset: launch the first fetch.
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = pc_q;
        end else if (bus.mem_ready) begin
          ir_d    = bus.mem_rdata[31:0];
          req_d   = 1'b0;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        rd_d     = rd;
        rwe_d    = 1'b0;
        fwe_d    = 1'b0;
        is_ld_d  = 1'b0;
        pcn_d    = pc_inc;
        state_d  = S_WB;
        retire_d = 1'b1;
        case (op)
          OP_NOP: ;
          OP_ADD: begin
            res_d = sum_add[DW-1:0]; fres_d = sum_add[DW];
            rwe_d = 1'b1;            fwe_d  = 1'b1;
          end
          OP_SUB: begin
            res_d = a - b; fres_d = (a < b);
            rwe_d = 1'b1;  fwe_d  = 1'b1;
          end
          OP_AND: begin
            res_d = a & b; fres_d = ((a & b) == '0);
            rwe_d = 1'b1;  fwe_d  = 1'b1;
          end
          OP_OR: begin
            res_d = a | b; fres_d = ((a | b) == '0);
            rwe_d = 1'b1;  fwe_d  = 1'b1;
          end
          OP_XOR: begin
            res_d = a ^ b; fres_d = ((a ^ b) == '0);
            rwe_d = 1'b1;  fwe_d  = 1'b1;
          end
          OP_ADDI: begin
            res_d = sum_addi[DW-1:0]; fres_d = sum_addi[DW];
            rwe_d = 1'b1;             fwe_d  = 1'b1;
          end
          OP_LD: begin
            is_ld_d  = 1'b1;
            rwe_d    = 1'b1;
            req_d    = 1'b1;
            we_d     = 1'b0;
            addr_d   = ea;
            state_d  = S_MEM;
            retire_d = 1'b0;
          end
          OP_ST: begin
            req_d    = 1'b1;
            we_d     = 1'b1;
            addr_d   = ea;
            wdata_d  = b;
            state_d  = S_MEM;
            retire_d = 1'b0;
          end
          OP_BZ:  if (a == '0)      pcn_d = pc_br;
          OP_BF:  if (flags_q[rs1]) pcn_d = pc_br;
          OP_JMP: pcn_d = AW'(a);
          OP_HALT: begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
          default: begin
            // Trap: no retire, pc stays on the faulting instruction.
            illegal_d = 1'b1;
            halted_d  = 1'b1;
            state_d   = S_HALT;
            retire_d  = 1'b0;
          end
        endcase
      end

      S_MEM: begin
        if (bus.mem_ready) begin
          req_d    = 1'b0;
          we_d     = 1'b0;
          retire_d = 1'b1;
          state_d  = S_WB;
          if (is_ld_q) res_d = bus.mem_rdata;
        end
      end

      S_WB: begin
        pc_d    = pcn_q;
        req_d   = 1'b1;
        we_d    = 1'b0;
        addr_d  = pcn_q;
        state_d = S_FETCH;
      end

      S_HALT: ;

      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      pcn_q     <= '0;
      ir_q      <= '0;
      res_q     <= '0;
      fres_q    <= 1'b0;
      rwe_q     <= 1'b0;
      fwe_q     <= 1'b0;
      is_ld_q   <= 1'b0;
      rd_q      <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      retire_q  <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pcn_q     <= pcn_d;
      ir_q      <= ir_d;
      res_q     <= res_d;
      fres_q    <= fres_d;
      rwe_q     <= rwe_d;
      fwe_q     <= fwe_d;
      is_ld_q   <= is_ld_d;
      rd_q      <= rd_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      retire_q  <= retire_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  // Register file and flags commit only in WB.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regs_q  <= '{default: '0};
      flags_q <= '0;
    end else if (state_q == S_WB) begin
      if (rwe_q) regs_q[rd_q]  <= res_q;
      if (fwe_q) flags_q[rd_q] <= fres_q;
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign retire        = retire_q;
  assign halted        = halted_q;
  assign illegal       = illegal_q;
  assign pc            = pc_q;

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: a memory model answers requests and a scoreboard
// queue of expected bus transactions is checked as each request completes.
module tb_cpu_core;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          retire, halted, illegal;
  logic [AW-1:0] pc;

  always #5 clock = ~clock;

  cpu_core_if #(.DW(DW), .AW(AW)) bus ();

  cpu_core #(.DW(DW), .AW(AW), .NREGS(8), .RESET_PC(32'h10)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .retire  (retire),
    .halted  (halted),
    .illegal (illegal),
    .pc      (pc)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  txn_t          exp_q[$];
  int            ret_cyc[$];
  logic [DW-1:0] mem [256];
  int            errors = 0;
  int            checks = 0;
  int            cyc_n  = 0;
  int            wait_cnt = 0;
  logic [AW-1:0] st_addr;
  logic          st_we;
  logic [DW-1:0] st_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2,
                                      input logic [13:0] imm);
    return {imm, rs2, rs1, rd, op};
  endfunction

  function automatic int wait_for(input logic [AW-1:0] a);
    if (a == 32'h20) return 2;
    if (a == 32'h50) return 1000;
    return 0;
  endfunction

  task automatic push_f(input logic [AW-1:0] a);
    exp_q.push_back('{1'b0, a, '0});
  endtask

  task automatic push_w(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back('{1'b1, a, d});
  endtask

  // One clock of the memory model, evaluated at the falling edge.
  task automatic cycle();
    txn_t e;
    @(negedge clock);
    cyc_n++;
    if (retire) ret_cyc.push_back(cyc_n);
    if (bus.mem_req) begin
      if (wait_cnt > 0) begin
        chk("hold_addr",  64'(bus.mem_addr),  64'(st_addr));
        chk("hold_we",    64'(bus.mem_we),    64'(st_we));
        chk("hold_wdata", 64'(bus.mem_wdata), 64'(st_wdata));
      end else begin
        st_addr  = bus.mem_addr;
        st_we    = bus.mem_we;
        st_wdata = bus.mem_wdata;
      end
      if (wait_cnt < wait_for(bus.mem_addr)) begin
        bus.mem_ready = 1'b0;
        wait_cnt++;
      end else begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mem[bus.mem_addr[7:0]];
        wait_cnt = 0;
        if (bus.mem_we) mem[bus.mem_addr[7:0]] = bus.mem_wdata;
        chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("txn_we",   64'(bus.mem_we),   64'(e.we));
          chk("txn_addr", 64'(bus.mem_addr), 64'(e.addr));
          if (e.we) chk("txn_wdata", 64'(bus.mem_wdata), 64'(e.wdata));
        end
      end
    end else begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.mem_rdata = DW'($urandom);
      wait_cnt = 0;
    end
  endtask

  task automatic run_until_halt(input int budget, input string tag);
    int n = 0;
    while (!halted && n < budget) begin
      cycle();
      n++;
    end
    chk(tag, 64'(halted), 64'd1);
  endtask

  task automatic quiet_after_halt(input string tag);
    int reqs = 0;
    int rets = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.mem_req) reqs++;
      if (retire) rets++;
    end
    chk({tag, "_no_req"},    64'(reqs), 64'd0);
    chk({tag, "_no_retire"}, 64'(rets), 64'd0);
  endtask

  initial begin
    int n;
    reset         = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    mem[8'h13] = enc(6'd6,  4'd1, 4'd0, 4'd0, 14'd5);
    mem[8'h14] = enc(6'd6,  4'd2, 4'd0, 4'd0, 14'h3FFF);
    mem[8'h15] = enc(6'd1,  4'd3, 4'd1, 4'd2, 14'd0);
    mem[8'h16] = enc(6'd2,  4'd4, 4'd1, 4'd1, 14'd0);
    mem[8'h17] = enc(6'd8,  4'd0, 4'd0, 4'd3, 14'h40);
    mem[8'h18] = enc(6'd10, 4'd0, 4'd3, 4'd0, 14'd2);
    mem[8'h19] = enc(6'd12, 4'd0, 4'd0, 4'd0, 14'd0);
    mem[8'h1A] = enc(6'd10, 4'd0, 4'd4, 4'd0, 14'd5);
    mem[8'h1B] = enc(6'd8,  4'd0, 4'd0, 4'd1, 14'h20);
    mem[8'h1C] = enc(6'd7,  4'd5, 4'd0, 4'd0, 14'h20);
    mem[8'h1D] = enc(6'd8,  4'd0, 4'd0, 4'd5, 14'h41);
    mem[8'h1E] = enc(6'd6,  4'd6, 4'd0, 4'd0, 14'd4);
    mem[8'h1F] = enc(6'd11, 4'd0, 4'd6, 4'd0, 14'd0);
    mem[8'h04] = enc(6'd9,  4'd0, 4'd0, 4'd0, 14'd3);
    mem[8'h07] = enc(6'd11, 4'd0, 4'd1, 4'd0, 14'd0);
    mem[8'h05] = enc(6'd6,  4'd7, 4'd0, 4'd0, 14'h24);
    mem[8'h06] = enc(6'd11, 4'd0, 4'd7, 4'd0, 14'd0);
    mem[8'h24] = enc(6'd8,  4'd0, 4'd0, 4'd7, 14'h42);
    mem[8'h25] = enc(6'h3F, 4'd0, 4'd0, 4'd0, 14'd0);

    push_f(32'h10); push_f(32'h11); push_f(32'h12); push_f(32'h13);
    push_f(32'h14); push_f(32'h15); push_f(32'h16);
    push_f(32'h17); push_w(32'h40, 32'd4);
    push_f(32'h18); push_f(32'h1A);
    push_f(32'h1B); push_w(32'h20, 32'd5);
    push_f(32'h1C); push_f(32'h20);
    push_f(32'h1D); push_w(32'h41, 32'd5);
    push_f(32'h1E); push_f(32'h1F);
    push_f(32'h04); push_f(32'h07); push_f(32'h05); push_f(32'h06);
    push_f(32'h24); push_w(32'h42, 32'h24);
    push_f(32'h25);

    #12;
    chk("rst_req",     64'(bus.mem_req),   64'd0);
    chk("rst_we",      64'(bus.mem_we),    64'd0);
    chk("rst_addr",    64'(bus.mem_addr),  64'd0);
    chk("rst_wdata",   64'(bus.mem_wdata), 64'd0);
    chk("rst_retire",  64'(retire),        64'd0);
    chk("rst_halted",  64'(halted),        64'd0);
    chk("rst_illegal", 64'(illegal),       64'd0);
    chk("rst_pc",      64'(pc),            64'h10);

    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("first_req",  64'(bus.mem_req),  64'd1);
    chk("first_addr", 64'(bus.mem_addr), 64'h10);

    run_until_halt(400, "prog1_halt");
    chk("illegal_flag", 64'(illegal),         64'd1);
    chk("illegal_pc",   64'(pc),              64'h25);
    chk("prog1_sb_empty", 64'(exp_q.size()),  64'd0);
    chk("prog1_retires",  64'(ret_cyc.size()), 64'd20);
    if (ret_cyc.size() >= 12) begin
      chk("nop_lat0", 64'(ret_cyc[1] - ret_cyc[0]),   64'd3);
      chk("nop_lat1", 64'(ret_cyc[2] - ret_cyc[1]),   64'd3);
      chk("st_lat",   64'(ret_cyc[7] - ret_cyc[6]),   64'd4);
      chk("st_wait_lat", 64'(ret_cyc[10] - ret_cyc[9]), 64'd6);
      chk("ld_wait_lat", 64'(ret_cyc[11] - ret_cyc[10]), 64'd6);
    end
    quiet_after_halt("illegal");
    chk("illegal_pc_hold", 64'(pc), 64'h25);

    // Second program: abort a stalled store with reset, then rerun to HALT.
    mem[8'h10] = enc(6'd6, 4'd1, 4'd0, 4'd0, 14'd7);
    mem[8'h11] = enc(6'd8, 4'd0, 4'd0, 4'd1, 14'h50);
    exp_q.delete();
    push_f(32'h10); push_f(32'h11);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    n = 0;
    while (!(bus.mem_req && bus.mem_we) && n < 40) begin
      cycle();
      n++;
    end
    chk("reach_mem_we", 64'(bus.mem_req && bus.mem_we), 64'd1);
    cycle();
    cycle();
    chk("abort_sb_empty", 64'(exp_q.size()), 64'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_req",   64'(bus.mem_req),   64'd0);
    chk("abort_we",    64'(bus.mem_we),    64'd0);
    chk("abort_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("abort_pc",    64'(pc),            64'h10);
    wait_cnt = 0;

    mem[8'h10] = enc(6'd8,  4'd0, 4'd0, 4'd1, 14'h51);
    mem[8'h11] = enc(6'd12, 4'd0, 4'd0, 4'd0, 14'd0);
    push_f(32'h10); push_w(32'h51, 32'd0); push_f(32'h11);
    ret_cyc.delete();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    run_until_halt(100, "prog2_halt");
    chk("halt_illegal",   64'(illegal),         64'd0);
    chk("halt_pc",        64'(pc),              64'h11);
    chk("prog2_retires",  64'(ret_cyc.size()),  64'd2);
    chk("prog2_sb_empty", 64'(exp_q.size()),    64'd0);
    quiet_after_halt("halt");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
